fifo_uart_tx: RTL and testbench

Downstream drain stage for the 16-entry, 8-bit synchronous FIFO. The block pops bytes from the FIFO read port and serialises each one as an 8N1 UART frame: one start bit, eight data bits LSB first, one stop bit. It consumes the FIFO's show-ahead read data, so the byte is valid whenever `fifo_empty` is low, and it owns the FIFO `rd` strobe.

---
 rtl/fifo_uart_tx.sv | 99 +++++++++
 tb/tb_fifo_uart_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops bytes from a show-ahead FIFO and sends them
// as 8N1 UART frames, back-to-back when data is waiting.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   baud_cnt, baud_cnt_n;
   logic [2:0]      bit_idx, bit_idx_n, idx_inc;
   logic [7:0]      shreg, shreg_n;
   logic            tx_n, tx_done_n;
   logic            last, fetch;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         shreg    <= shreg_n;
         tx       <= tx_n;
         tx_done  <= tx_done_n;
      end
   end

   always_comb begin
      last       = (baud_cnt == LAST);
      fetch      = (state == IDLE) || ((state == STOP) && last);
      fifo_rd    = fetch & enable & ~fifo_empty & ~rst;
      busy       = (state != IDLE);
      idx_inc    = bit_idx + 3'd1;
      state_n    = state;
      baud_cnt_n = last ? '0 : baud_cnt + 1'b1;
      bit_idx_n  = bit_idx;
      shreg_n    = shreg;
      tx_n       = tx;
      tx_done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            baud_cnt_n = '0;
            tx_n       = 1'b1;
         end
         START: begin
            if (last) begin
               state_n = DATA;
               tx_n    = shreg[0];
            end
         end
         DATA: begin
            if (last) begin
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_idx_n = idx_inc;
                  tx_n      = shreg[idx_inc];
               end
            end
         end
         STOP: begin
            if (last) begin
               tx_done_n = 1'b1;
               state_n   = IDLE;
               tx_n      = 1'b1;
            end
         end
      endcase
      // A fetch overrides the stop-bit exit so frames chain with no gap
      if (fifo_rd) begin
         shreg_n    = fifo_data;
         state_n    = START;
         baud_cnt_n = '0;
         bit_idx_n  = '0;
         tx_n       = 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx with a 16-deep show-ahead FIFO model;
// one DUT at 4 clocks/bit and one at 2 clocks/bit share the FIFO.
module tb_fifo_uart_tx;

   logic       clk = 0;
   logic       rst = 1;
   logic       enable = 0;
   logic       sel = 0;
   logic       wr = 0;
   logic [7:0] wdata = 0;

   logic [7:0] mem [16];
   logic [3:0] wp = 0, rp = 0;
   logic [4:0] cnt = 0;
   logic       rd_l = 0;
   logic       underflow = 0;
   logic       fifo_empty, fifo_full;
   logic [7:0] fifo_data;

   logic rd1, tx1, busy1, done1;
   logic rd2, tx2, busy2, done2;
   logic e1, e2;
   logic rd_sel, tx_sel, busy_sel, done_sel;

   int checks = 0;
   int failures = 0;
   int ecount = 0;
   logic [7:0] exp_q [$];
   int rd_q [$];
   int done_q [$];

   assign fifo_empty = (cnt == 0);
   assign fifo_full  = (cnt == 16);
   assign fifo_data  = mem[rp];
   assign e1 = sel | fifo_empty;
   assign e2 = ~sel | fifo_empty;
   assign rd_sel   = sel ? rd2 : rd1;
   assign tx_sel   = sel ? tx2 : tx1;
   assign busy_sel = sel ? busy2 : busy1;
   assign done_sel = sel ? done2 : done1;

   fifo_uart_tx #(.CLKS_PER_BIT(4)) u_dut1 (
      .clk(clk), .rst(rst), .enable(enable),
      .fifo_empty(e1), .fifo_data(fifo_data),
      .fifo_rd(rd1), .tx(tx1), .busy(busy1), .tx_done(done1)
   );

   fifo_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
      .clk(clk), .rst(rst), .enable(enable),
      .fifo_empty(e2), .fifo_data(fifo_data),
      .fifo_rd(rd2), .tx(tx2), .busy(busy2), .tx_done(done2)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      ecount++;
   end

   always @(posedge clk) begin
      if (wr && !fifo_full) begin
         mem[wp] <= wdata;
         wp <= wp + 4'd1;
      end
      if (rd_l && !fifo_empty) rp <= rp + 4'd1;
      if (rd_l && fifo_empty) underflow <= 1'b1;
      cnt <= cnt + 5'(wr && !fifo_full) - 5'(rd_l && !fifo_empty);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Pop strobe is latched mid-cycle; edge indices of pops and done pulses
   initial forever begin
      @(negedge clk);
      #2;
      rd_l = rd_sel;
      if (rd_sel) rd_q.push_back(ecount);
      if (done_sel) done_q.push_back(ecount - 1);
   end

   // Frame decoder: pos counts half-cycle-offset samples from the start edge
   initial begin
      int pos, n, j;
      logic [7:0] b;
      pos = -1;
      b = 0;
      forever begin
         @(negedge clk);
         #1;
         n = sel ? 2 : 4;
         if (pos < 0) begin
            if (tx_sel === 1'b0) begin
               pos = 0;
               b = 0;
            end
         end else begin
            pos++;
            if (pos < 10 * n && busy_sel !== 1'b1) begin
               pos = -1;
            end else if (pos == 10 * n) begin
               chk("tx_done_at_frame_end", int'(done_sel), 1);
               pos = (tx_sel === 1'b0) ? 0 : -1;
               b = 0;
            end else if (pos % n == n / 2) begin
               j = pos / n;
               if (j == 0) chk("start_bit", int'(tx_sel), 0);
               else if (j <= 8) b[j-1] = tx_sel;
               else begin
                  chk("stop_bit", int'(tx_sel), 1);
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL frame_unexpected actual=%0h required=none", b);
                  end else begin
                     chk("frame_byte", int'(b), int'(exp_q.pop_front()));
                  end
               end
            end
         end
      end
   end

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b, input bit expect_it);
      wr = 1;
      wdata = b;
      if (expect_it) exp_q.push_back(b);
      @(negedge clk);
      wr = 0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int i;
      i = 0;
      while (done_q.size() < target && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk("wait_done_timeout", done_q.size() >= target ? 1 : 0, 1);
   endtask

   initial begin
      int bad, t, e0, i, r0, d0;
      rst = 1;
      enable = 1;
      step(2);
      #1;
      chk("reset_tx1", int'(tx1), 1);
      chk("reset_busy1", int'(busy1), 0);
      chk("reset_done1", int'(done1), 0);
      chk("reset_tx2", int'(tx2), 1);
      chk("reset_busy2", int'(busy2), 0);

      // single byte, pushed while reset still holds the pop off
      push(8'hA5, 1);
      #1;
      chk("rd_held_in_reset", int'(rd1), 0);
      rst = 0;
      wait_done(1, 200);
      step(1);
      #1;
      chk("single_busy_fall", int'(busy1), 0);
      chk("single_rd_count", rd_q.size(), 1);
      chk("single_pop_to_done", done_q[0] - rd_q[0], 40);

      // back-to-back
      push(8'h00, 1);
      push(8'hFF, 1);
      push(8'h3C, 1);
      wait_done(4, 400);
      chk("b2b_rd_count", rd_q.size(), 4);
      for (int k = 1; k <= 3; k++)
         chk("b2b_pop_to_done", done_q[k] - rd_q[k], 40);
      for (int k = 1; k <= 2; k++) begin
         chk("b2b_pop_spacing", rd_q[k+1] - rd_q[k], 40);
         chk("b2b_no_gap", rd_q[k+1] - done_q[k], 0);
      end
      #1;
      chk("b2b_fifo_empty", int'(fifo_empty), 1);
      step(1);

      // empty FIFO with enable high
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         #1;
         if (tx1 !== 1'b1 || busy1 !== 1'b0 || rd1 !== 1'b0) bad++;
      end
      chk("empty_idle_bad_cycles", bad, 0);
      chk("empty_rd_count", rd_q.size(), 4);
      chk("empty_underflow", int'(underflow), 0);

      // enable gating
      push(8'h81, 1);
      push(8'h42, 1);
      step(10);
      enable = 0;
      wait_done(5, 200);
      step(20);
      #1;
      chk("gate_rd_count", rd_q.size(), 5);
      chk("gate_busy", int'(busy1), 0);
      chk("gate_fifo_cnt", int'(cnt), 1);
      t = ecount;
      enable = 1;
      step(1);
      chk("gate_restart_edge", rd_q[5], t);
      wait_done(6, 200);

      // reset during data bit 3 of 0x55
      step(2);
      push(8'h55, 0);
      push(8'h99, 1);
      chk("rst_pop_seen", rd_q.size(), 7);
      e0 = rd_q[6];
      i = 0;
      while (ecount < e0 + 18 && i < 100) begin
         @(negedge clk);
         i++;
      end
      rst = 1;
      step(1);
      #1;
      chk("rst_mid_tx", int'(tx1), 1);
      chk("rst_mid_busy", int'(busy1), 0);
      chk("rst_mid_done", int'(done1), 0);
      chk("rst_mid_rd", int'(rd1), 0);
      chk("rst_mid_fifo_cnt", int'(cnt), 1);
      rst = 0;
      wait_done(7, 300);
      chk("rst_after_rd_count", rd_q.size(), 8);

      // full drain at 2 clocks per bit
      step(2);
      enable = 0;
      sel = 1;
      for (int k = 0; k < 16; k++) push(8'(k), 1);
      #1;
      chk("drain_full_before", int'(fifo_full), 1);
      r0 = rd_q.size();
      d0 = done_q.size();
      enable = 1;
      step(1);
      #1;
      chk("drain_full_cleared", int'(fifo_full), 0);
      i = 0;
      while (rd_q.size() < r0 + 16 && i < 500) begin
         @(negedge clk);
         i++;
      end
      #1;
      chk("drain_empty_after_16", int'(fifo_empty), 1);
      wait_done(d0 + 16, 600);
      chk("drain_total_cycles", done_q[d0+15] - rd_q[r0], 320);
      chk("drain_underflow", int'(underflow), 0);

      step(5);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
